serial_seq: RTL



---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_pkg.sv
// ============================================================================
// serial_pkg : shared state encoding, clamp helper and width default for the
//              serial transaction sequencer and clock generator.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam int P_W_DEF = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] clamp1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_seq.sv
// ============================================================================
// serial_seq : transaction sequencer feeding the serial clock generator;
//              owns the cnt timebase and shifts data out msb-first.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module serial_seq
  import serial_pkg::*;
#(
  parameter int   P_W      = P_W_DEF,
  parameter logic P_D_IDLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] din,
  input  logic [7:0]  ncyc_in,
  input  logic [31:0] n0_in,
  input  logic [31:0] n1_in,
  input  logic [31:0] n2_in,
  output logic [31:0] cnt,
  output logic [7:0]  ncyc,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic [31:0] n2,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  state_e         st_q, st_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [7:0]     ncyc_q, ncyc_d;
  logic [31:0]    n0_q, n0_d;
  logic [31:0]    n1_q, n1_d;
  logic [31:0]    n2_q, n2_d;
  logic [P_W-1:0] sr_q, sr_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [31:0]    nxt_q, nxt_d;
  logic           dout_q, dout_d;
  logic           done_q, done_d;

  logic [31:0]    ncyc_wide;
  logic [7:0]     ncyc_cl;
  logic [7:0]     sh_amt;
  logic [31:0]    din_aligned;
  logic [31:0]    cnt_inc;

  // Events are matched against the value cnt takes on this edge, so bit k
  // lands on the same edge where cnt becomes n0 + k*(n1+n2).
  always_comb begin
    ncyc_wide = clamp1({24'd0, ncyc_in});
    ncyc_cl   = ncyc_wide[7:0];
    if (ncyc_cl > 8'(P_W)) begin
      ncyc_cl = 8'(P_W);
    end
    sh_amt      = 8'(P_W) - ncyc_cl;
    din_aligned = din << sh_amt;
    cnt_inc     = cnt_q + 32'd1;
  end

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    ncyc_d    = ncyc_q;
    n0_d      = n0_q;
    n1_d      = n1_q;
    n2_d      = n2_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    nxt_d     = nxt_q;
    dout_d    = dout_q;
    done_d    = 1'b0;

    case (st_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        if (start) begin
          st_d      = ST_RUN;
          ncyc_d    = ncyc_cl;
          n0_d      = clamp1(n0_in);
          n1_d      = clamp1(n1_in);
          n2_d      = clamp1(n2_in);
          sr_d      = din_aligned[P_W-1:0];
          bit_cnt_d = 8'd0;
          nxt_d     = clamp1(n0_in);
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (cnt_inc == nxt_q) begin
          if (bit_cnt_q < ncyc_q) begin
            dout_d    = sr_q[P_W-1];
            sr_d      = sr_q << 1;
            nxt_d     = nxt_q + n1_q + n2_q;
            bit_cnt_d = bit_cnt_q + 8'd1;
          end else begin
            st_d   = ST_IDLE;
            cnt_d  = 32'd0;
            dout_d = P_D_IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= 32'd0;
      ncyc_q    <= 8'd1;
      n0_q      <= 32'd1;
      n1_q      <= 32'd1;
      n2_q      <= 32'd1;
      sr_q      <= '0;
      bit_cnt_q <= 8'd0;
      nxt_q     <= 32'd1;
      dout_q    <= P_D_IDLE;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      ncyc_q    <= ncyc_d;
      n0_q      <= n0_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      nxt_q     <= nxt_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign ncyc = ncyc_q;
  assign n0   = n0_q;
  assign n1   = n1_q;
  assign n2   = n2_q;
  assign dout = dout_q;
  assign busy = (st_q == ST_RUN);
  assign done = done_q;

endmodule

`default_nettype wire
